// File: rtl/ser2par_framer.sv
// Serial-to-parallel framer: collects 1..W serial bits per frame and presents them
// right-aligned on a valid/ready output, with mid-frame abort and sticky overrun flag.
module ser2par_framer #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CW        = $clog2(W + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_ser_in,
    input  logic [CW-1:0] i_len,
    input  logic          i_out_ready,
    output logic [W-1:0]  o_par_out,
    output logic          o_out_valid,
    output logic          o_busy,
    output logic          o_aborted,
    output logic          o_overrun
);

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    localparam logic [CW-1:0] LenMax = CW'(W);

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_lf;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_par;
    logic          r_valid;
    logic          r_busy;
    logic          r_aborted;
    logic          r_overrun;

    logic [CW-1:0] w_len_clamped;
    logic [CW-1:0] w_cnt_next;
    logic [W-1:0]  w_first;
    logic [W-1:0]  w_shift_next;
    logic          w_start;

    always_comb begin
        w_len_clamped = (i_len == '0 || i_len > LenMax) ? LenMax : i_len;
        w_cnt_next    = r_cnt + CW'(1);
        w_first       = {{(W - 1){1'b0}}, i_ser_in};
        // MSB-first shifts up from bit 0; LSB-first drops each bit at its arrival index.
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[W-2:0], i_ser_in};
        end else begin
            w_shift_next = r_shift | (W'(i_ser_in) << r_cnt);
        end
        w_start = i_en && ((r_state == StIdle) || (r_state == StHold && i_out_ready));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_lf      <= '0;
            r_shift   <= '0;
            r_par     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_aborted <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            if (w_start) begin
                r_lf <= w_len_clamped;
                if (w_len_clamped == CW'(1)) begin
                    r_par   <= w_first;
                    r_valid <= 1'b1;
                    r_state <= StHold;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_shift <= '0;
                end else begin
                    r_shift <= w_first;
                    r_cnt   <= CW'(1);
                    r_valid <= 1'b0;
                    r_state <= StShift;
                    r_busy  <= 1'b1;
                end
            end else begin
                case (r_state)
                    StIdle: ;
                    StShift: begin
                        if (i_en) begin
                            if (w_cnt_next == r_lf) begin
                                r_par   <= w_shift_next;
                                r_valid <= 1'b1;
                                r_state <= StHold;
                                r_busy  <= 1'b0;
                                r_cnt   <= '0;
                                r_shift <= '0;
                            end else begin
                                r_shift <= w_shift_next;
                                r_cnt   <= w_cnt_next;
                            end
                        end else begin
                            r_aborted <= 1'b1;
                            r_state   <= StIdle;
                            r_busy    <= 1'b0;
                            r_cnt     <= '0;
                            r_shift   <= '0;
                        end
                    end
                    StHold: begin
                        if (i_out_ready) begin
                            r_valid <= 1'b0;
                            r_state <= StIdle;
                        end else if (i_en) begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_par_out   = r_par;
    assign o_out_valid = r_valid;
    assign o_busy      = r_busy;
    assign o_aborted   = r_aborted;
    assign o_overrun   = r_overrun;

endmodule
